cpu_ctrl_sequencer: RTL and testbench
=====================================

Name: cpu_ctrl_sequencer

Overview:
Multi-cycle control FSM for the RV32I datapath. It replaces the clock-derived per-class control (PC/ALU selects, register and memory clocks) with registered-state enable strobes. It sequences fetch, decode, execute, memory and writeback for each instruction class, and handles memory wait-states through a ready handshake. It sits between the instruction register, the memory interface and the PC/ALU/register-file datapath.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for mem_ready per access; 0 disables the timeout
STATE_W, 3, width of the state debug output

Ports:
CLK  input  1  processor clock
RST  input  1  synchronous active-high reset
insn  input  32  instruction register contents, valid from DECODE onward
mem_ready  input  1  memory completed the current read/write this cycle
branch_taken  input  1  branch comparator result, sampled in EXEC
ir_load  output  1  load instruction register from memory read data
pc_en  output  1  PC register update strobe
addr_sel  output  1  0 = memory address from PC, 1 = from ALU
pc_next_sel  output  1  0 = PC+4, 1 = PC ALU result
pc_alu_sel  output  1  PC ALU operand: 0 = PC+imm (JAL/branch), 1 = rs1+imm (JALR)
sub_sra  output  1  ALU subtract/arith-shift control
rd_we  output  1  register-file write enable
mem_re  output  1  memory read request
mem_we  output  1  memory write request
state  output  STATE_W  current FSM state (debug)
illegal  output  1  sticky: unsupported opcode trapped
mem_err  output  1  sticky: memory timeout trapped

Behaviour:
- Clock and reset: one clock CLK. RST is synchronous and active-high.
- Reset values: state=FETCH, illegal=0, mem_err=0, wait counter=0, all strobes 0 while RST is high.
- Output type: all strobes are Moore outputs, decoded from the registered state and insn.
- States and transitions:
  - FETCH: addr_sel=0, mem_re=1. Holds until mem_ready. On mem_ready: ir_load=1, then go to DECODE.
  - DECODE: classifies insn[6:0]. Unsupported opcode sets illegal=1 and goes to TRAP; otherwise goes to EXEC.
  - EXEC, Branch (1100011): sub_sra=1, pc_en=1, pc_next_sel=branch_taken, pc_alu_sel=0; then FETCH.
  - EXEC, Load/Store: sets up the ALU address; then MEM.
  - EXEC, all other classes: go to WB.
  - MEM: addr_sel=1. Load drives mem_re=1; store drives mem_we=1. Holds until mem_ready. Load then goes to WB. Store pulses pc_en=1 with pc_next_sel=0, then FETCH.
  - WB: rd_we=1 and pc_en=1. JAL: pc_next_sel=1, pc_alu_sel=0. JALR: pc_next_sel=1, pc_alu_sel=1. Others: pc_next_sel=0. Then FETCH.
  - TRAP: all strobes 0. Held until RST.
- sub_sra:
  - OP (0110011): sub_sra = insn[30].
  - OP-IMM (0010011): sub_sra = insn[30] only when funct3=101, else 0.
  - Branch: 1. Everything else: 0.
- Latency:
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - Load: 5 cycles. Store: 4 cycles. Branch: 3 cycles.
  - Each memory wait-state adds 1 cycle.
- Timeout:
  - The counter increments each cycle in FETCH/MEM while mem_ready=0, and clears on state change.
  - When the count reaches MEM_TIMEOUT (if MEM_TIMEOUT≠0), set mem_err=1 and go to TRAP.
  - mem_ready in the same cycle as reaching the limit wins: the access completes and there is no trap.
- Reset mid-access: returns to FETCH next cycle. Sticky flags clear. Any in-flight store is dropped (mem_we low from the reset cycle).
- At most one of mem_re/mem_we is high in any cycle. pc_en is high exactly once per retired instruction.

Optional Feature:
- Macro: CPU_CTRL_SINGLE_STEP_EN.
- With it defined:
  - Adds input step (1 bit).
  - The FSM idles in a STEP_WAIT state, all strobes 0, before every FETCH, until step=1, then enters FETCH.
  - After reset the FSM starts in STEP_WAIT.
- Without it: no port, no state. Last state transitions straight to FETCH.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state encoding constants (FETCH, DECODE, EXEC, MEM, WB, TRAP, STEP_WAIT);
  - RV32I opcode constants;
  - instruction-class enum (ALU_R, ALU_I, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ILLEGAL).
- Sub-module insn_class_decoder: combinational, insn[6:0] to class plus illegal flag. It is shared with future decoders.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready always 1 → FETCH, DECODE, EXEC, WB. ir_load in cycle 1; rd_we=1 and pc_en=1 with pc_next_sel=0 in cycle 4.
- LW (0x0000A103), 2 wait-states in MEM → MEM lasts 3 cycles with addr_sel=1, mem_re=1, then WB with rd_we=1. Total 7 cycles.
- BEQ (0x00208463): branch_taken=1 → EXEC with pc_en=1, pc_next_sel=1, sub_sra=1, no rd_we. Repeat with branch_taken=0 → pc_next_sel=0.
- Opcode 0x0000007F → DECODE sets illegal=1, TRAP holds 10 cycles with all strobes 0. RST=1 for one cycle → FETCH, illegal=0.
- SW (0x0020A023), mem_ready held low, MEM_TIMEOUT=15 → mem_we high 15 cycles, then mem_err=1 and TRAP. Variant with mem_ready on the 15th cycle → no trap.
- RST asserted in MEM of SW → next cycle FETCH with mem_we=0 and pc_en=0. With CPU_CTRL_SINGLE_STEP_EN: FSM waits in STEP_WAIT until a step pulse, then runs exactly one instruction.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the RV32I multi-cycle control sequencer and its
// instruction-class decoder. This package holds the FSM state encoding, the
// RV32I major opcodes, the instruction-class enum, and a helper that selects
// the ALU subtract/arith-shift control for a class.
// No ports (package).
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXEC      = 3'd2,
        MEM       = 3'd3,
        WB        = 3'd4,
        TRAP      = 3'd5,
        STEP_WAIT = 3'd6
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // funct3 shared by SRL/SRA and SRLI/SRAI
    localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

    localparam int CLS_W = 4;

    typedef enum logic [CLS_W-1:0] {
        ALU_R,
        ALU_I,
        LUI,
        AUIPC,
        JAL,
        JALR,
        BRANCH,
        LOAD,
        STORE,
        ILLEGAL
    } insn_class_t;

    // For immediate ALU ops bit 30 is part of the immediate, so it only
    // selects SRAI over SRLI; ADDI and friends never subtract.
    function automatic logic sub_sra_for(input insn_class_t cls,
                                         input logic [2:0]  funct3,
                                         input logic        bit30);
        logic alt;
        alt = 1'b0;
        case (cls)
            ALU_R:   alt = bit30;
            ALU_I:   alt = (funct3 == F3_SHIFT_RIGHT) ? bit30 : 1'b0;
            BRANCH:  alt = 1'b1;
            default: alt = 1'b0;
        endcase
        return alt;
    endfunction

endpackage

// File: rtl/insn_class_decoder.sv
// insn_class_decoder
// Combinational RV32I major-opcode classifier, shared with other decoders.
// Ports:
//   opcode   in  7          insn[6:0]
//   insn_cls out CLS_W      instruction class (insn_class_t encoding)
//   illegal  out 1          opcode is not one this core supports
module insn_class_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0]       opcode,
    output logic [CLS_W-1:0] insn_cls,
    output logic             illegal
);

    always_comb begin
        insn_cls = ILLEGAL;
        illegal  = 1'b0;
        case (opcode)
            OPC_OP:     insn_cls = ALU_R;
            OPC_OP_IMM: insn_cls = ALU_I;
            OPC_LUI:    insn_cls = LUI;
            OPC_AUIPC:  insn_cls = AUIPC;
            OPC_JAL:    insn_cls = JAL;
            OPC_JALR:   insn_cls = JALR;
            OPC_BRANCH: insn_cls = BRANCH;
            OPC_LOAD:   insn_cls = LOAD;
            OPC_STORE:  insn_cls = STORE;
            default:    illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_sequencer.sv
// cpu_ctrl_sequencer
// Multi-cycle control FSM for the RV32I datapath. Sequences fetch, decode,
// execute, memory and writeback per instruction class, waits on mem_ready for
// memory accesses, and traps on unsupported opcodes or memory timeouts.
// Optional feature macro: CPU_CTRL_SINGLE_STEP_EN adds input 'step' and a
// STEP_WAIT idle state before every FETCH (also the reset state).
// Ports:
//   CLK, RST (sync, active-high)
//   insn[31:0], mem_ready, branch_taken, [step]          inputs
//   ir_load, pc_en, addr_sel, pc_next_sel, pc_alu_sel,
//   sub_sra, rd_we, mem_re, mem_we                        strobes
//   state[STATE_W-1:0] (debug), illegal, mem_err (sticky) status
module cpu_ctrl_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int STATE_W     = 3
)
(
    input  logic               CLK,
    input  logic               RST,
    input  logic [31:0]        insn,
    input  logic               mem_ready,
    input  logic               branch_taken,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic               step,
`endif
    output logic               ir_load,
    output logic               pc_en,
    output logic               addr_sel,
    output logic               pc_next_sel,
    output logic               pc_alu_sel,
    output logic               sub_sra,
    output logic               rd_we,
    output logic               mem_re,
    output logic               mem_we,
    output logic [STATE_W-1:0] state,
    output logic               illegal,
    output logic               mem_err
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    // The trap fires on the not-ready cycle that brings the count to
    // MEM_TIMEOUT, i.e. when the registered count already equals limit-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

`ifdef CPU_CTRL_SINGLE_STEP_EN
    localparam state_t RESTART = STEP_WAIT;
`else
    localparam state_t RESTART = FETCH;
`endif

    state_t           cur_state;
    state_t           next_state;
    logic             next_illegal;
    logic             next_mem_err;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] next_wait_cnt;
    logic             waiting;
    logic             timeout_hit;
    logic [CLS_W-1:0] cls_bits;
    insn_class_t      cls;
    logic             cls_illegal;
    logic             alu_alt;
    logic             unused_insn_bits;

    insn_class_decoder u_decoder (
        .opcode   (insn[6:0]),
        .insn_cls (cls_bits),
        .illegal  (cls_illegal)
    );

    assign cls              = insn_class_t'(cls_bits);
    assign alu_alt          = sub_sra_for(cls, insn[14:12], insn[30]);
    assign unused_insn_bits = ^{insn[31], insn[29:15], insn[11:7]};

    assign waiting     = ((cur_state == FETCH) || (cur_state == MEM)) && !mem_ready;
    assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == CNT_LAST);

    assign state = STATE_W'(cur_state);

    // State, sticky flags and wait counter register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cur_state <= RESTART;
            illegal   <= 1'b0;
            mem_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            cur_state <= next_state;
            illegal   <= next_illegal;
            mem_err   <= next_mem_err;
            wait_cnt  <= next_wait_cnt;
        end
    end

    // Next-state logic. A completing access always beats a timeout that
    // would expire in the same cycle.
    always_comb begin
        next_state   = cur_state;
        next_illegal = illegal;
        next_mem_err = mem_err;
        case (cur_state)
            STEP_WAIT: begin
`ifdef CPU_CTRL_SINGLE_STEP_EN
                if (step) next_state = FETCH;
`else
                next_state = FETCH;
`endif
            end
            FETCH: begin
                if (mem_ready) begin
                    next_state = DECODE;
                end else if (timeout_hit) begin
                    next_state   = TRAP;
                    next_mem_err = 1'b1;
                end
            end
            DECODE: begin
                if (cls_illegal) begin
                    next_state   = TRAP;
                    next_illegal = 1'b1;
                end else begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (cls == BRANCH)                     next_state = RESTART;
                else if (cls == LOAD || cls == STORE)  next_state = MEM;
                else                                   next_state = WB;
            end
            MEM: begin
                if (mem_ready) begin
                    next_state = (cls == LOAD) ? WB : RESTART;
                end else if (timeout_hit) begin
                    next_state   = TRAP;
                    next_mem_err = 1'b1;
                end
            end
            WB:      next_state = RESTART;
            TRAP:    next_state = TRAP;
            default: next_state = TRAP;
        endcase

        next_wait_cnt = wait_cnt;
        if (next_state != cur_state)  next_wait_cnt = '0;
        else if (waiting)             next_wait_cnt = wait_cnt + 1'b1;
    end

    // Strobe decode from the registered state and insn. Everything is forced
    // low during reset so an in-flight store is dropped in the reset cycle.
    // ir_load follows mem_ready so the IR captures the read data on the
    // completing FETCH cycle; store pc_en likewise fires only on completion.
    always_comb begin
        ir_load     = 1'b0;
        pc_en       = 1'b0;
        addr_sel    = 1'b0;
        pc_next_sel = 1'b0;
        pc_alu_sel  = 1'b0;
        sub_sra     = 1'b0;
        rd_we       = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        if (!RST) begin
            case (cur_state)
                FETCH: begin
                    mem_re  = 1'b1;
                    ir_load = mem_ready;
                end
                EXEC: begin
                    sub_sra = alu_alt;
                    if (cls == BRANCH) begin
                        pc_en       = 1'b1;
                        pc_next_sel = branch_taken;
                    end
                end
                MEM: begin
                    addr_sel = 1'b1;
                    if (cls == LOAD) begin
                        mem_re = 1'b1;
                    end else if (cls == STORE) begin
                        mem_we = 1'b1;
                        pc_en  = mem_ready;
                    end
                end
                WB: begin
                    rd_we   = 1'b1;
                    pc_en   = 1'b1;
                    sub_sra = alu_alt;
                    if (cls == JAL) begin
                        pc_next_sel = 1'b1;
                    end else if (cls == JALR) begin
                        pc_next_sel = 1'b1;
                        pc_alu_sel  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// tb_cpu_ctrl_sequencer
// Self-checking bench for cpu_ctrl_sequencer. A behavioural model turns each
// instruction (opcode, wait-states, branch outcome) into the expected
// per-cycle sequence of state, strobes and flags; each test task replays that
// sequence against the DUT. Handles CPU_CTRL_SINGLE_STEP_EN when defined.
module tb_cpu_ctrl_sequencer;
    import cpu_ctrl_pkg::*;

    localparam int MEM_TIMEOUT = 15;

    logic        CLK;
    logic        RST;
    logic [31:0] insn;
    logic        mem_ready;
    logic        branch_taken;
`ifdef CPU_CTRL_SINGLE_STEP_EN
    logic        step;
    localparam state_t IDLE_ST   = STEP_WAIT;
    localparam bit     STEP_MODE = 1'b1;
`else
    localparam state_t IDLE_ST   = FETCH;
    localparam bit     STEP_MODE = 1'b0;
`endif
    logic        ir_load, pc_en, addr_sel, pc_next_sel, pc_alu_sel;
    logic        sub_sra, rd_we, mem_re, mem_we, illegal, mem_err;
    logic [2:0]  state;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        state_t st;
        logic   rdy;
        logic   stp;
        logic   ir_load;
        logic   pc_en;
        logic   addr_sel;
        logic   pc_next_sel;
        logic   pc_alu_sel;
        logic   sub_sra;
        logic   rd_we;
        logic   mem_re;
        logic   mem_we;
        logic   illegal;
        logic   mem_err;
    } rec_t;

    rec_t exp_q[$];

    cpu_ctrl_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .STATE_W(3)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .insn         (insn),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
`ifdef CPU_CTRL_SINGLE_STEP_EN
        .step         (step),
`endif
        .ir_load      (ir_load),
        .pc_en        (pc_en),
        .addr_sel     (addr_sel),
        .pc_next_sel  (pc_next_sel),
        .pc_alu_sel   (pc_alu_sel),
        .sub_sra      (sub_sra),
        .rd_we        (rd_we),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .state        (state),
        .illegal      (illegal),
        .mem_err      (mem_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- reference model ----------------

    function automatic rec_t blank(input state_t st);
        rec_t r;
        r     = '0;
        r.st  = st;
        r.rdy = 1'b1;
        return r;
    endfunction

    function automatic logic [13:0] exp_vec(input rec_t r);
        return {r.st, r.ir_load, r.pc_en, r.addr_sel, r.pc_next_sel, r.pc_alu_sel,
                r.sub_sra, r.rd_we, r.mem_re, r.mem_we, r.illegal, r.mem_err};
    endfunction

    function automatic logic [13:0] out_vec();
        return {state, ir_load, pc_en, addr_sel, pc_next_sel, pc_alu_sel,
                sub_sra, rd_we, mem_re, mem_we, illegal, mem_err};
    endfunction

    function automatic bit is_legal(input logic [6:0] opc);
        return opc inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                           7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011};
    endfunction

    // sub_sra: R-type uses bit 30; I-type only for the right-shift funct3; branches compare by subtraction
    function automatic logic exp_alt(input logic [31:0] in);
        if (in[6:0] == 7'b0110011) return in[30];
        if (in[6:0] == 7'b0010011) return (in[14:12] == 3'd5) ? in[30] : 1'b0;
        if (in[6:0] == 7'b1100011) return 1'b1;
        return 1'b0;
    endfunction

    // Not-ready cycles of one access; returns 1 if the wait limit is hit (trap appended).
    function automatic bit model_access(input rec_t tmpl, input int waits);
        rec_t r;
        r     = tmpl;
        r.rdy = 1'b0;
        if (MEM_TIMEOUT != 0 && waits >= MEM_TIMEOUT) begin
            for (int k = 0; k < MEM_TIMEOUT; k++) exp_q.push_back(r);
            r = blank(TRAP);
            r.mem_err = 1'b1;
            exp_q.push_back(r);
            return 1'b1;
        end
        for (int k = 0; k < waits; k++) exp_q.push_back(r);
        return 1'b0;
    endfunction

    function automatic void model_insn(input logic [31:0] in, input int fw, input int mw, input logic bt);
        rec_t r;
        logic [6:0] opc;
        logic alt;
        opc = in[6:0];
        alt = exp_alt(in);
        if (STEP_MODE) begin
            r = blank(STEP_WAIT);
            r.stp = 1'b1;
            exp_q.push_back(r);
        end
        r = blank(FETCH);
        r.mem_re = 1'b1;
        if (model_access(r, fw)) return;
        r.ir_load = 1'b1;
        exp_q.push_back(r);
        exp_q.push_back(blank(DECODE));
        if (!is_legal(opc)) begin
            r = blank(TRAP);
            r.illegal = 1'b1;
            exp_q.push_back(r);
            return;
        end
        if (opc == 7'b1100011) begin
            r = blank(EXEC);
            r.sub_sra = 1'b1;
            r.pc_en = 1'b1;
            r.pc_next_sel = bt;
            exp_q.push_back(r);
            return;
        end
        if (opc == 7'b0000011 || opc == 7'b0100011) begin
            exp_q.push_back(blank(EXEC));
            r = blank(MEM);
            r.addr_sel = 1'b1;
            r.mem_re = (opc == 7'b0000011);
            r.mem_we = (opc == 7'b0100011);
            if (model_access(r, mw)) return;
            if (opc == 7'b0100011) begin
                r.pc_en = 1'b1;
                exp_q.push_back(r);
                return;
            end
            exp_q.push_back(r);
            r = blank(WB);
            r.rd_we = 1'b1;
            r.pc_en = 1'b1;
            exp_q.push_back(r);
            return;
        end
        r = blank(EXEC);
        r.sub_sra = alt;
        exp_q.push_back(r);
        r = blank(WB);
        r.rd_we = 1'b1;
        r.pc_en = 1'b1;
        r.sub_sra = alt;
        r.pc_next_sel = (opc == 7'b1101111) || (opc == 7'b1100111);
        r.pc_alu_sel = (opc == 7'b1100111);
        exp_q.push_back(r);
    endfunction

    function automatic void model_trap_hold(input int n, input logic ill, input logic merr);
        rec_t r;
        r = blank(TRAP);
        r.illegal = ill;
        r.mem_err = merr;
        for (int k = 0; k < n; k++) exp_q.push_back(r);
    endfunction

    // ---------------- stimulus helpers ----------------

    task automatic drive(input rec_t r);
        mem_ready = r.rdy;
`ifdef CPU_CTRL_SINGLE_STEP_EN
        step = r.stp;
`endif
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        mem_ready = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        rec_t r;
        RST = 1'b1;
        insn = $urandom;
        for (int k = 0; k < 2; k++) begin
            mem_ready = (k == 0);
            @(negedge CLK);
            r = blank(IDLE_ST);
            if (out_vec() !== exp_vec(r)) begin
                $display("[TB] FAIL test_reset[%0d]: got %b expected %b", k, out_vec(), exp_vec(r));
            end else passes++;
            checks++;
            @(posedge CLK);
            #1;
        end
        RST = 1'b0;
    endtask

    task automatic test_insn(input string name, input logic [31:0] in, input int fw, input int mw, input logic bt);
        rec_t r;
        int cyc;
        insn = in;
        branch_taken = bt;
        model_insn(in, fw, mw, bt);
        cyc = 0;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            drive(r);
            if (out_vec() !== exp_vec(r)) begin
                $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, out_vec(), exp_vec(r));
            end else passes++;
            checks++;
            cyc++;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_illegal();
        rec_t r;
        int cyc;
        do_reset();
        insn = 32'h0000007F;
        model_insn(insn, 0, 0, 1'b0);
        model_trap_hold(9, 1'b1, 1'b0);
        cyc = 0;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            drive(r);
            if (out_vec() !== exp_vec(r)) begin
                $display("[TB] FAIL test_illegal cycle %0d: got %b expected %b", cyc, out_vec(), exp_vec(r));
            end else passes++;
            checks++;
            cyc++;
            @(posedge CLK);
            #1;
        end
        RST = 1'b1;
        mem_ready = 1'b1;
        @(negedge CLK);
        r = blank(TRAP);
        r.illegal = 1'b1;
        if (out_vec() !== exp_vec(r)) begin
            $display("[TB] FAIL test_illegal_rst: got %b expected %b", out_vec(), exp_vec(r));
        end else passes++;
        checks++;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        test_insn("illegal_recover", 32'h00500093, 0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        rec_t r;
        int cyc;
        do_reset();
        insn = 32'h0020A023;
        model_insn(insn, 0, 20, 1'b0);
        model_trap_hold(4, 1'b0, 1'b1);
        cyc = 0;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            drive(r);
            if (out_vec() !== exp_vec(r)) begin
                $display("[TB] FAIL test_timeout cycle %0d: got %b expected %b", cyc, out_vec(), exp_vec(r));
            end else passes++;
            checks++;
            cyc++;
            @(posedge CLK);
            #1;
        end
        do_reset();
        test_insn("sw_ready_at_limit", 32'h0020A023, 0, MEM_TIMEOUT - 1, 1'b0);
        do_reset();
        test_insn("fetch_timeout", 32'h00500093, MEM_TIMEOUT, 0, 1'b0);
        do_reset();
        test_insn("fetch_ready_at_limit", 32'h00500093, MEM_TIMEOUT - 1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_store();
        rec_t r;
        int prefix;
        do_reset();
        insn = 32'h0020A023;
        model_insn(insn, 0, 20, 1'b0);
        prefix = (STEP_MODE ? 1 : 0) + 6;
        for (int cyc = 0; cyc < prefix; cyc++) begin
            r = exp_q.pop_front();
            drive(r);
            if (out_vec() !== exp_vec(r)) begin
                $display("[TB] FAIL test_mid_store cycle %0d: got %b expected %b", cyc, out_vec(), exp_vec(r));
            end else passes++;
            checks++;
            @(posedge CLK);
            #1;
        end
        exp_q.delete();
        RST = 1'b1;
        mem_ready = 1'b0;
        @(negedge CLK);
        r = blank(MEM);
        if (out_vec() !== exp_vec(r)) begin
            $display("[TB] FAIL test_mid_store_rst: got %b expected %b", out_vec(), exp_vec(r));
        end else passes++;
        checks++;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        mem_ready = 1'b1;
`ifdef CPU_CTRL_SINGLE_STEP_EN
        step = 1'b0;
`endif
        @(negedge CLK);
        r = blank(IDLE_ST);
        if (!STEP_MODE) begin
            r.mem_re = 1'b1;
            r.ir_load = 1'b1;
        end
        if (out_vec() !== exp_vec(r)) begin
            $display("[TB] FAIL test_mid_store_after: got %b expected %b", out_vec(), exp_vec(r));
        end else passes++;
        checks++;
        @(posedge CLK);
        #1;
        do_reset();
    endtask

    task automatic test_random();
        logic [6:0] opcs [9];
        logic [31:0] in;
        opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                 7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011};
        do_reset();
        for (int i = 0; i < 40; i++) begin
            in = $urandom;
            in[6:0] = opcs[$urandom_range(0, 8)];
            test_insn("random", in, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef CPU_CTRL_SINGLE_STEP_EN
    task automatic test_step();
        rec_t r;
        int cyc;
        do_reset();
        insn = 32'h00500093;
        branch_taken = 1'b0;
        r = blank(STEP_WAIT);
        for (int k = 0; k < 4; k++) exp_q.push_back(r);
        model_insn(insn, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++) exp_q.push_back(r);
        cyc = 0;
        while (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            drive(r);
            if (out_vec() !== exp_vec(r)) begin
                $display("[TB] FAIL test_step cycle %0d: got %b expected %b", cyc, out_vec(), exp_vec(r));
            end else passes++;
            checks++;
            cyc++;
            @(posedge CLK);
            #1;
        end
    endtask
`endif

    initial begin
        RST = 1'b1;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        insn = 32'h0;
`ifdef CPU_CTRL_SINGLE_STEP_EN
        step = 1'b0;
`endif
        @(posedge CLK);
        #1;
        test_reset();
        test_insn("addi", 32'h00500093, 0, 0, 1'b0);
        test_insn("lw_2wait", 32'h0000A103, 0, 2, 1'b0);
        test_insn("beq_taken", 32'h00208463, 0, 0, 1'b1);
        test_insn("beq_not_taken", 32'h00208463, 0, 0, 1'b0);
        test_insn("sw", 32'h0020A023, 1, 1, 1'b0);
        test_insn("jal", 32'h0000006F, 0, 0, 1'b0);
        test_insn("jalr", 32'h00008067, 0, 0, 1'b0);
        test_insn("srai", 32'h4010D093, 0, 0, 1'b0);
        test_insn("sub", 32'h402080B3, 0, 0, 1'b0);
        test_illegal();
        test_timeout();
        test_reset_mid_store();
        test_random();
`ifdef CPU_CTRL_SINGLE_STEP_EN
        test_step();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
